// File: rtl/alu_execute_unit.sv
// EX-stage execution unit: single-cycle ADD/SUB/OR/AND plus an iterative
// shift-add MUL that stalls the upstream pipeline while it runs.
module alu_execute_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       ALU_control_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             stall_o
);

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpMul = 3'b010;
    localparam logic [2:0] OpOr  = 3'b100;
    localparam logic [2:0] OpAnd = 3'b101;

    localparam logic [CNT_W-1:0] LastIter = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StMulRun,
        StDone
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;

    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] acc_step;
    logic             accept;

    assign ready_o = (state_q != StMulRun);
    assign stall_o = (state_q == StMulRun);
    assign accept  = valid_i & ready_o & ~flush_i;

    // Single-cycle results; MUL and undefined codes fall through to zero.
    always_comb begin
        alu_result = '0;
        case (ALU_control_i)
            OpAdd:   alu_result = data1_i + data2_i;
            OpSub:   alu_result = data1_i - data2_i;
            OpOr:    alu_result = data1_i | data2_i;
            OpAnd:   alu_result = data1_i & data2_i;
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        acc_step = acc_q;
        if (mplier_q[0]) begin
            acc_step = acc_q + mcand_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= StIdle;
            count_q  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            valid_o  <= 1'b0;
            result_o <= '0;
            zero_o   <= 1'b1;
        end else if (flush_i) begin
            // Discard any MUL in flight; the last committed result stays visible.
            state_q <= StIdle;
            valid_o <= 1'b0;
        end else begin
            case (state_q)
                StMulRun: begin
                    acc_q    <= acc_step;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    count_q  <= count_q + CNT_W'(1);
                    valid_o  <= 1'b0;
                    if (count_q == LastIter) begin
                        result_o <= acc_step;
                        zero_o   <= (acc_step == '0);
                        valid_o  <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                default: begin
                    valid_o <= 1'b0;
                    state_q <= StIdle;
                    if (accept) begin
                        if (ALU_control_i == OpMul) begin
                            mcand_q  <= data1_i;
                            mplier_q <= data2_i;
                            acc_q    <= '0;
                            count_q  <= '0;
                            state_q  <= StMulRun;
                        end else begin
                            result_o <= alu_result;
                            zero_o   <= (alu_result == '0);
                            valid_o  <= 1'b1;
                            state_q  <= StDone;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_execute_unit.sv
// Directed self-checking bench for alu_execute_unit.
module tb_alu_execute_unit;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        valid_in;
    logic        ready;
    logic [2:0]  alu_ctrl;
    logic [31:0] data1;
    logic [31:0] data2;
    logic        valid_out;
    logic [31:0] result;
    logic        zero;
    logic        stall;

    int checks = 0;
    int errors = 0;

    alu_execute_unit #(
        .WIDTH(32),
        .CNT_W(5)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .valid_i      (valid_in),
        .ready_o      (ready),
        .ALU_control_i(alu_ctrl),
        .data1_i      (data1),
        .data2_i      (data2),
        .valid_o      (valid_out),
        .result_o     (result),
        .zero_o       (zero),
        .stall_o      (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        valid_in = v;
        alu_ctrl = op;
        data1    = a;
        data2    = b;
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        flush = 1'b0;
        drive(1'b1, 3'b000, 32'h1, 32'h2);
        tick();
        tick();
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        rst = 1'b1;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_out); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero got %b want 1", zero); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    endtask

    task automatic test_alu();
        drive(1'b1, 3'b000, 32'hFFFF_FFFF, 32'h1);
        tick();
        checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL add_valid got %b want 1", valid_out); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL add_wrap got %h want 0", result); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL add_zero got %b want 1", zero); end
        drive(1'b1, 3'b001, 32'd5, 32'd5);
        tick();
        checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL sub_valid got %b want 1", valid_out); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL sub_eq got %h want 0", result); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL sub_zero got %b want 1", zero); end
        drive(1'b1, 3'b001, 32'd3, 32'd5);
        tick();
        checks++; if (result !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_wrap got %h want fffffffe", result); end
        drive(1'b1, 3'b000, 32'd7, 32'd3);
        tick();
        checks++; if (result !== 32'd10) begin errors++; $display("FAIL add_basic got %h want a", result); end
        drive(1'b1, 3'b100, 32'hF0, 32'h0F);
        tick();
        checks++; if (result !== 32'hFF) begin errors++; $display("FAIL or_result got %h want ff", result); end
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL or_zero got %b want 0", zero); end
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        tick();
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL idle_valid got %b want 0", valid_out); end
        checks++; if (result !== 32'hFF) begin errors++; $display("FAIL idle_hold got %h want ff", result); end
    endtask

    // Runs one MUL; optionally scrambles inputs while the unit is busy.
    task automatic test_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                            input logic disturb);
        int stall_cnt = 0;
        int valid_at  = 0;
        int pulses    = 0;
        drive(1'b1, 3'b010, a, b);
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (n == 1) begin
                checks++; if (ready !== 1'b0) begin errors++; $display("FAIL mul_ready got %b want 0", ready); end
            end
            if (stall === 1'b1) stall_cnt++;
            if (valid_out === 1'b1) begin
                pulses++;
                if (valid_at == 0) valid_at = n;
            end
            if (disturb && n <= 32) begin
                drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom);
            end else begin
                drive(1'b0, 3'b000, 32'h0, 32'h0);
            end
        end
        checks++; if (stall_cnt != 32) begin errors++; $display("FAIL mul_stall_cycles got %0d want 32", stall_cnt); end
        checks++; if (valid_at != 33) begin errors++; $display("FAIL mul_latency got %0d want 33", valid_at); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL mul_pulses got %0d want 1", pulses); end
        checks++; if (result !== exp) begin errors++; $display("FAIL mul_result got %h want %h", result, exp); end
    endtask

    task automatic test_flush();
        int pulses = 0;
        // Flush beats a simultaneous valid_i.
        flush = 1'b1;
        drive(1'b1, 3'b000, 32'd1, 32'd2);
        tick();
        flush = 1'b0;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL flush_accept_valid got %b want 0", valid_out); end
        checks++; if (result !== 32'h2345_6780) begin errors++; $display("FAIL flush_accept_result got %h want 23456780", result); end
        drive(1'b1, 3'b010, 32'd9, 32'd9);
        for (int n = 1; n <= 10; n++) begin
            tick();
            drive(1'b0, 3'b000, 32'h0, 32'h0);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %b want 0", stall); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b want 1", ready); end
        for (int n = 0; n < 40; n++) begin
            if (valid_out === 1'b1) pulses++;
            tick();
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL flush_no_valid got %0d want 0", pulses); end
        checks++; if (result !== 32'h2345_6780) begin errors++; $display("FAIL flush_result got %h want 23456780", result); end
        drive(1'b1, 3'b010, 32'd9, 32'd9);
        for (int n = 1; n <= 20; n++) begin
            tick();
            drive(1'b0, 3'b000, 32'h0, 32'h0);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL midrst_result got %h want 0", result); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL midrst_zero got %b want 1", zero); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL midrst_stall got %b want 0", stall); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", ready); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", valid_out); end
    endtask

    task automatic test_undefined();
        drive(1'b1, 3'b000, 32'd1, 32'd1);
        tick();
        drive(1'b1, 3'b111, 32'h1234, 32'h1234);
        tick();
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL undef_valid got %b want 1", valid_out); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL undef_result got %h want 0", result); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL undef_zero got %b want 1", zero); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 3'b010, 32'd3, 32'd5);
        for (int n = 1; n <= 33; n++) begin
            tick();
            drive(1'b0, 3'b000, 32'h0, 32'h0);
        end
        checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL b2b_mul_valid got %b want 1", valid_out); end
        checks++; if (result !== 32'd15) begin errors++; $display("FAIL b2b_mul_result got %h want f", result); end
        drive(1'b1, 3'b101, 32'hFF, 32'h0F);
        tick();
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL b2b_and_valid got %b want 1", valid_out); end
        checks++; if (result !== 32'h0F) begin errors++; $display("FAIL b2b_and_result got %h want f", result); end
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL b2b_and_zero got %b want 0", zero); end
        tick();
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL b2b_end_valid got %b want 0", valid_out); end
    endtask

    initial begin
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        test_reset();
        test_alu();
        test_mul(32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 1'b0);
        test_mul(32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFF9, 1'b0);
        test_mul(32'h1234_5678, 32'h10, 32'h2345_6780, 1'b1);
        test_flush();
        test_undefined();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
